ram_rd: RTL

Sequential block-RAM reader for the tinyNPU data path. On a start command it issues read strobes to a BRAM port at consecutive word addresses, absorbs the fixed BRAM read latency, and delivers the words on a valid/ready output stream. A small credit-controlled FIFO guarantees that no returning word is ever lost under backpressure. It is the read-side counterpart of the BRAM write port logic that fills the same memories.

---
 rtl/ram_rd_if.sv | 29 ++
 rtl/ram_rd.sv | 119 +++++++++++
 2 files changed

// File: rtl/ram_rd_if.sv
// Bundles the command, BRAM-port and output-stream signals of ram_rd.
// The master side is the reader itself; the slave side is the BRAM plus the stream consumer.
interface ram_rd_if #(
   parameter int WIDTH = 32
);
   logic             i_start;
   logic [WIDTH-1:0] i_base_addr;
   logic [WIDTH-1:0] i_length;
   logic             o_rst_ram;
   logic             o_en_ram;
   logic [3:0]       o_wr_ram;
   logic [WIDTH-1:0] o_ram_addr;
   logic [WIDTH-1:0] i_ram_data;
   logic [WIDTH-1:0] o_data;
   logic             o_data_valid;
   logic             i_data_ready;
   logic             o_busy;
   logic             o_done;

   modport master (
      input  i_start, i_base_addr, i_length, i_ram_data, i_data_ready,
      output o_rst_ram, o_en_ram, o_wr_ram, o_ram_addr, o_data, o_data_valid, o_busy, o_done
   );

   modport slave (
      output i_start, i_base_addr, i_length, i_ram_data, i_data_ready,
      input  o_rst_ram, o_en_ram, o_wr_ram, o_ram_addr, o_data, o_data_valid, o_busy, o_done
   );
endinterface

// File: rtl/ram_rd.sv
// Sequential BRAM reader: issues word reads, absorbs the BRAM latency and streams the words out
// through a 4-entry show-ahead FIFO guarded by a credit check, so no returning word is ever lost.
module ram_rd #(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 1
) (
   input logic      i_clk,
   input logic      i_reset,
   ram_rd_if.master bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t             state;
   state_t             state_next;
   logic [WIDTH-1:0]   addr;
   logic [WIDTH-1:0]   remaining;
   logic [LATENCY-1:0] pipe;
   logic [WIDTH-1:0]   fifo_mem [4];
   logic [1:0]         wr_ptr;
   logic [1:0]         rd_ptr;
   logic [2:0]         fifo_count;
   logic [2:0]         in_flight;
   logic               issue;
   logic               fifo_wr;
   logic               fifo_pop;
   logic               accept;

   always_comb begin
      in_flight = '0;
      for (int i = 0; i < LATENCY; i++) begin
         in_flight = in_flight + {2'b00, pipe[i]};
      end
   end

   // Reads in the pipe plus words in the FIFO never exceed the FIFO depth.
   assign issue    = (state == ISSUE) && ((in_flight + fifo_count) < 3'd4);
   assign fifo_wr  = pipe[LATENCY-1];
   assign fifo_pop = (fifo_count != 3'd0) && bus.i_data_ready;
   assign accept   = (state == IDLE) && bus.i_start;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // DRAIN ends in the cycle that the final word leaves, so o_done lands right after it.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.i_start) begin
               state_next = (bus.i_length == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            if (issue && (remaining == WIDTH'(1))) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if ((in_flight == 3'd0) &&
                ((fifo_count == 3'd0) || ((fifo_count == 3'd1) && fifo_pop))) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         addr       <= '0;
         remaining  <= '0;
         pipe       <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (accept) begin
            addr      <= bus.i_base_addr;
            remaining <= bus.i_length;
         end else if (issue) begin
            addr      <= addr + WIDTH'(4);
            remaining <= remaining - WIDTH'(1);
         end
         pipe <= LATENCY'({pipe, issue});
         if (fifo_wr) begin
            wr_ptr <= wr_ptr + 2'd1;
         end
         if (fifo_pop) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         case ({fifo_wr, fifo_pop})
            2'b10:   fifo_count <= fifo_count + 3'd1;
            2'b01:   fifo_count <= fifo_count - 3'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (fifo_wr) begin
         fifo_mem[wr_ptr] <= bus.i_ram_data;
      end
   end

   assign bus.o_rst_ram    = i_reset;
   assign bus.o_en_ram     = issue;
   assign bus.o_wr_ram     = 4'b0000;
   assign bus.o_ram_addr   = addr;
   assign bus.o_data       = fifo_mem[rd_ptr];
   assign bus.o_data_valid = (fifo_count != 3'd0);
   assign bus.o_busy       = (state != IDLE);
   assign bus.o_done       = (state == DONE);
endmodule
